eth_tx_frame_sched: RTL and testbench

//  Frame-granular scheduler that shares one GMII transmit MAC between PORTS AXI4-Stream frame sources.

---
 rtl/eth_tx_sched_pkg.sv | 17 +
 rtl/eth_rr_arbiter.sv | 34 +++
 rtl/eth_tx_frame_sched.sv | 149 ++++++++++++++
 tb/tb_eth_tx_frame_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
// Shared constants for the Ethernet transmit frame scheduler: FSM encodings and
// the 802.3x pause timer geometry.
package eth_tx_sched_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam int QUANTA_BYTES  = 64;
    localparam int QUANTA_W      = 16;
    localparam int SUB_W         = $clog2(QUANTA_BYTES);
    localparam int PAUSE_TIMER_W = QUANTA_W + SUB_W;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational frame arbiter: strict priority (lowest index) or round-robin
// starting at ptr_i and wrapping.
module eth_rr_arbiter
    import eth_tx_sched_pkg::*;
#(
    parameter int PORTS    = 2,
    parameter int CL_PORTS = clog2_min1(PORTS)
) (
    input  logic [PORTS-1:0]    req_i,
    input  logic [CL_PORTS-1:0] ptr_i,
    input  logic                strict_i,
    output logic [PORTS-1:0]    gnt_oh_o,
    output logic [CL_PORTS-1:0] gnt_idx_o
);

    logic [CL_PORTS-1:0] cand;
    logic                found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = CL_PORTS'(strict_i ? k : (int'(ptr_i) + k) % PORTS);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                gnt_oh_o[cand] = 1'b1;
                gnt_idx_o      = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_sched.sv
// Frame-granular scheduler sharing one GMII transmit MAC between PORTS AXIS
// sources, with 802.3x pause hold-off applied only between frames.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no grant; waits for a request with the pause timer at 0
// ST_XFER | grant_index owns the MAC until its tlast is accepted
module eth_tx_frame_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int CL_PORTS   = clog2_min1(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          clk_enable,
    input  logic                          mii_select,
    input  logic                          cfg_strict_prio,
    input  logic                          pause_enable,
    input  logic                          pause_req,
    input  logic [QUANTA_W-1:0]           pause_quanta,
    output logic                          grant_valid,
    output logic [CL_PORTS-1:0]           grant_index,
    output logic                          pause_active
);

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("eth_tx_frame_sched: only DATA_WIDTH=8 is supported");
    end
    if (PORTS < 1 || PORTS > 16) begin : g_bad_ports
        $error("eth_tx_frame_sched: PORTS must be 1..16");
    end

    logic [0:0]               state_q, state_d;
    logic [CL_PORTS-1:0]      grant_idx_q, grant_idx_d;
    logic [CL_PORTS-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PAUSE_TIMER_W-1:0] timer_q, timer_d;
    logic                     pause_active_q;
    logic                     mii_phase_q, mii_phase_d;

    logic [PORTS-1:0]         arb_oh;
    logic [CL_PORTS-1:0]      arb_idx;
    logic                     xfer;
    logic                     frame_done;
    logic                     byte_tick;

    eth_rr_arbiter #(
        .PORTS    (PORTS),
        .CL_PORTS (CL_PORTS)
    ) u_arb (
        .req_i     (s_axis_tvalid),
        .ptr_i     (rr_ptr_q),
        .strict_i  (cfg_strict_prio),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign xfer       = (state_q == ST_XFER);
    assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if ((|arb_oh) && (timer_q == '0)) begin
                    state_d     = ST_XFER;
                    grant_idx_d = arb_idx;
                end
            end
            default: begin
                if (frame_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (int'(grant_idx_q) == PORTS - 1) ? '0
                                                                : grant_idx_q + CL_PORTS'(1);
                end
            end
        endcase
    end

    // Pure mux on the registered grant; an underflowing source shows through as tvalid=0.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (xfer && (grant_idx_q == CL_PORTS'(i))) begin
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tlast     = s_axis_tlast[i];
                m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

    // In MII mode a byte time spans two enabled cycles; count on the second.
    assign byte_tick = clk_enable && (!mii_select || mii_phase_q);

    always_comb begin
        mii_phase_d = mii_select ? (mii_phase_q ^ clk_enable) : 1'b0;
        timer_d     = timer_q;
        if (!pause_enable) begin
            timer_d = '0;
        end else if (pause_req) begin
            timer_d = {pause_quanta, {SUB_W{1'b0}}};
        end else if (byte_tick && (timer_q != '0)) begin
            timer_d = timer_q - PAUSE_TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_idx_q    <= '0;
            rr_ptr_q       <= '0;
            timer_q        <= '0;
            pause_active_q <= 1'b0;
            mii_phase_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            rr_ptr_q       <= rr_ptr_d;
            timer_q        <= timer_d;
            pause_active_q <= (timer_d != '0);
            mii_phase_q    <= mii_phase_d;
        end
    end

    assign grant_valid  = xfer;
    assign grant_index  = grant_idx_q;
    assign pause_active = pause_active_q;

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Scoreboard bench for eth_tx_frame_sched: directed frames per port, expected
// beats queued at issue time and checked by an independent output monitor.
module tb_eth_tx_frame_sched;

    localparam int PORTS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        clk_enable, mii_select, cfg_strict_prio, pause_enable, pause_req;
    logic [15:0] pause_quanta;
    logic        grant_valid;
    logic [0:0]  grant_index;
    logic        pause_active;

    always #5 clk = ~clk;

    eth_tx_frame_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .cfg_strict_prio (cfg_strict_prio),
        .pause_enable    (pause_enable),
        .pause_req       (pause_req),
        .pause_quanta    (pause_quanta),
        .grant_valid     (grant_valid),
        .grant_index     (grant_index),
        .pause_active    (pause_active)
    );

    typedef struct packed {
        logic [0:0] port;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t exp_q[$];
    int    q_len[PORTS][$];
    int    q_fid[PORTS][$];
    int    beat[PORTS];
    logic  acc[PORTS];
    int    gap_beat[PORTS];
    int    gap_left[PORTS];
    int    errors = 0;
    int    checks = 0;
    int    ce_div = 1;
    int    ce_cnt = 0;

    function automatic logic [7:0] pat(input int p, input int fid, input int b);
        return 8'(p * 67 + fid * 13 + b * 7 + 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load_src(input int p, input int fid, input int len);
        q_len[p].push_back(len);
        q_fid[p].push_back(fid);
    endtask

    task automatic expect_frame(input int p, input int fid, input int len);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            e.port = 1'(p);
            e.data = pat(p, fid, b);
            e.last = (b == len - 1);
            e.user = 1'(fid & 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_sources();
        exp_q.delete();
        for (int p = 0; p < PORTS; p++) begin
            q_len[p].delete();
            q_fid[p].delete();
            beat[p]     = 0;
            acc[p]      = 1'b0;
            gap_beat[p] = -1;
            gap_left[p] = 0;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !grant_valid &&
                q_len[0].size() == 0 && q_len[1].size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_grant(input string name, input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant_valid) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    // Issue a pause request on a cycle whose clk_enable is low, so the MII phase is known.
    task automatic pause_sync(input logic mii, input logic [15:0] quanta);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!clk_enable) break;
        end
        mii_select   = mii;
        pause_quanta = quanta;
        pause_req    = 1'b1;
        cyc();
        pause_req    = 1'b0;
    endtask

    task automatic count_hold(input string name, input int expect_n);
        int n, viol;
        n    = 0;
        viol = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!pause_active) break;
            if (clk_enable) n++;
            if (grant_valid) viol++;
        end
        chk({name, "_enables"}, n, expect_n);
        chk({name, "_grant_while_paused"}, viol, 0);
    endtask

    initial begin : ce_gen
        clk_enable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ce_cnt++;
            clk_enable = ((ce_cnt % ce_div) == 0);
        end
    end

    initial begin : src_driver
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                if (acc[p] && q_len[p].size() > 0) begin
                    beat[p]++;
                    if (beat[p] >= q_len[p][0]) begin
                        void'(q_len[p].pop_front());
                        void'(q_fid[p].pop_front());
                        beat[p] = 0;
                    end
                end
                if (gap_left[p] > 0 && beat[p] == gap_beat[p]) begin
                    s_axis_tvalid[p] = 1'b0;
                    gap_left[p]--;
                end else if (q_len[p].size() > 0) begin
                    s_axis_tvalid[p]       = 1'b1;
                    s_axis_tdata[p*8 +: 8] = pat(p, q_fid[p][0], beat[p]);
                    s_axis_tlast[p]        = (beat[p] == q_len[p][0] - 1);
                    s_axis_tuser[p]        = 1'(q_fid[p][0] & 1);
                end else begin
                    s_axis_tvalid[p] = 1'b0;
                    s_axis_tlast[p]  = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        beat_t e, got;
        forever begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++)
                acc[p] = rst_n && s_axis_tvalid[p] && s_axis_tready[p];
            if (rst_n && m_axis_tvalid && m_axis_tready) begin
                got = {grant_index, m_axis_tdata, m_axis_tlast, m_axis_tuser[0]};
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", int'(got), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", int'(got), int'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int gaps, n, ended, viol;
        rst_n           = 1'b0;
        m_axis_tready   = 1'b1;
        mii_select      = 1'b0;
        cfg_strict_prio = 1'b0;
        pause_enable    = 1'b1;
        pause_req       = 1'b0;
        pause_quanta    = '0;
        flush_sources();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", int'(s_axis_tready), 0);
        chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant_index", int'(grant_index), 0);
        chk("rst_pause_active", int'(pause_active), 0);
        rst_n = 1'b1;

        // Round-robin, three 64-byte frames per port.
        cyc();
        for (int f = 0; f < 3; f++) begin
            load_src(0, f, 64);
            load_src(1, 10 + f, 64);
        end
        for (int f = 0; f < 3; f++) begin
            expect_frame(0, f, 64);
            expect_frame(1, 10 + f, 64);
        end
        wait_drain("t1_rr_drain", 1500);

        // Strict priority: port0 drains completely before port1.
        cyc();
        cfg_strict_prio = 1'b1;
        for (int f = 0; f < 3; f++) begin
            load_src(0, 20 + f, 8);
            expect_frame(0, 20 + f, 8);
        end
        load_src(1, 30, 8);
        expect_frame(1, 30, 8);
        wait_drain("t2_strict_drain", 300);

        // Pause quanta=2 in GMII mode: 128 byte times.
        cfg_strict_prio = 1'b0;
        ce_div          = 2;
        pause_sync(1'b0, 16'd2);
        load_src(0, 40, 8);
        expect_frame(0, 40, 8);
        count_hold("t3_gmii", 128);
        wait_drain("t3_drain", 200);

        // Same in MII mode: two enabled cycles per byte time.
        pause_sync(1'b1, 16'd2);
        load_src(1, 41, 8);
        expect_frame(1, 41, 8);
        count_hold("t4_mii", 256);
        wait_drain("t4_drain", 200);

        // Pause mid-frame: frame finishes, next frame waits for the full reload.
        cyc();
        load_src(0, 42, 64);
        expect_frame(0, 42, 64);
        wait_grant("t4b_grant", 100);
        repeat (10) @(posedge clk);
        #2;
        pause_quanta = 16'd1;
        pause_req    = 1'b1;
        load_src(1, 43, 8);
        expect_frame(1, 43, 8);
        cyc();
        pause_req = 1'b0;
        n     = 0;
        ended = 0;
        viol  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!pause_active) break;
            if (clk_enable) n++;
            if (!grant_valid) ended = 1;
            else if (ended != 0) viol++;
        end
        chk("t4b_frame_finished_under_pause", ended, 1);
        chk("t4b_regrant_while_paused", viol, 0);
        chk_range("t4b_reload_enables", n, 127, 128);
        wait_drain("t4b_drain", 300);

        // Source underflow: 5-cycle tvalid gap, grant held through it.
        cyc();
        mii_select      = 1'b0;
        ce_div          = 1;
        cfg_strict_prio = 1'b1;
        gap_beat[0]     = 6;
        gap_left[0]     = 5;
        load_src(0, 50, 16);
        load_src(1, 51, 8);
        expect_frame(0, 50, 16);
        expect_frame(1, 51, 8);
        wait_grant("t5_grant", 100);
        gaps = 0;
        for (int i = 0; i < 200; i++) begin
            if (!grant_valid) break;
            if (!m_axis_tvalid) gaps++;
            @(negedge clk);
        end
        chk("t5_gap_cycles", gaps, 5);
        wait_drain("t5_drain", 200);

        // Pause enable gating and quanta=0 clear.
        cyc();
        pause_quanta = 16'd5;
        pause_req    = 1'b1;
        cyc();
        pause_req = 1'b0;
        @(negedge clk);
        chk("t7_loaded", int'(pause_active), 1);
        cyc();
        pause_quanta = 16'd0;
        pause_req    = 1'b1;
        cyc();
        pause_req = 1'b0;
        @(negedge clk);
        chk("t7_quanta0_clears", int'(pause_active), 0);
        cyc();
        pause_quanta = 16'd5;
        pause_req    = 1'b1;
        cyc();
        pause_req    = 1'b0;
        pause_enable = 1'b0;
        cyc();
        @(negedge clk);
        chk("t7_disable_clears", int'(pause_active), 0);
        cyc();
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        @(negedge clk);
        chk("t7_req_ignored_disabled", int'(pause_active), 0);
        pause_enable = 1'b1;

        // Reset mid-frame; pointer is 1 beforehand, port0 must win afterwards.
        cyc();
        cfg_strict_prio = 1'b0;
        load_src(0, 60, 8);
        expect_frame(0, 60, 8);
        wait_drain("t6_pre_drain", 100);
        cyc();
        load_src(0, 61, 64);
        load_src(1, 62, 64);
        expect_frame(1, 62, 64);
        wait_grant("t6_grant", 100);
        chk("t6_rr_pointer_before_reset", int'(grant_index), 1);
        repeat (5) @(posedge clk);
        #2;
        pause_quanta = 16'd100;
        pause_req    = 1'b1;
        cyc();
        pause_req = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        flush_sources();
        chk("t6_rst_s_tready", int'(s_axis_tready), 0);
        chk("t6_rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("t6_rst_grant_valid", int'(grant_valid), 0);
        chk("t6_rst_grant_index", int'(grant_index), 0);
        chk("t6_rst_pause_active", int'(pause_active), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        load_src(0, 63, 8);
        load_src(1, 64, 8);
        expect_frame(0, 63, 8);
        expect_frame(1, 64, 8);
        wait_drain("t6_post_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
